calc_fsm: RTL and testbench

Main control state machine of the FPGA calculator. It decodes one 4-bit keypad code per key press into one of three actions: clear, digit entry or operation entry. It steers the ALU through `digit`, `operation` and `clear_ALU`, and hands every accepted event to the display controller through an `update_DISP` / `busy_DISP` handshake. It sits between the keypad scanner and the ALU/display blocks.

---
 rtl/calc_fsm.sv | 181 ++++++++++++++++++
 tb/tb_calc_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : calc_fsm
//  Description : Main control FSM of the calculator. Decodes one keypad code
//                per key press into clear / digit / operation events, drives
//                the ALU controls and hands each accepted event to the display
//                controller through an update_DISP / busy_DISP handshake.
//
//  Ports       : clk         - system clock (12 MHz)
//                rst         - asynchronous active-high reset
//                key         - keypad code (0-9 digit, 10 add, 11 sub,
//                              12 mul, 14 equals, 13 none, 15 clear)
//                full_ACC    - accumulator full (blocks digits and operations)
//                full_AUX    - aux operand full (blocks digits only)
//                busy_DISP   - display controller refreshing
//                digit       - last accepted digit (held)
//                operation   - last accepted operation (00 add, 01 sub,
//                              10 mul, 11 equals; held)
//                update_DISP - one-cycle display refresh strobe
//                clear_ALU   - one-cycle ALU clear strobe
//
//  Options     : CALC_FSM_TIMEOUT_EN - when defined, WAIT_HI gives up after
//                TIMEOUT_CYCLES cycles without busy_DISP and moves to RELEASE.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_fsm #(
    parameter logic [3:0] KEY_NONE       = 4'd13,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       full_ACC,
    input  logic       busy_DISP,
    input  logic       full_AUX,
    output logic [3:0] digit,
    output logic [1:0] operation,
    output logic       update_DISP,
    output logic       clear_ALU
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_ACT     = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [3:0] c_KEY_CLEAR = 4'd15;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_key;
    logic [3:0] r_digit;
    logic [1:0] r_operation;
    logic       r_update;
    logic       r_clear;

    logic       w_is_clear;
    logic       w_is_digit;
    logic       w_is_op;
    logic       w_accept;
    logic [1:0] w_op_code;
    logic       w_timeout;

    // ------------------------------------------------------------------
    // Key classification of the latched code
    // ------------------------------------------------------------------
    always_comb begin
        w_is_op   = 1'b0;
        w_op_code = 2'b00;
        case (r_key)
            4'd10:   begin w_is_op = 1'b1; w_op_code = 2'b00; end
            4'd11:   begin w_is_op = 1'b1; w_op_code = 2'b01; end
            4'd12:   begin w_is_op = 1'b1; w_op_code = 2'b10; end
            4'd14:   begin w_is_op = 1'b1; w_op_code = 2'b11; end
            default: begin w_is_op = 1'b0; w_op_code = 2'b00; end
        endcase
    end

    assign w_is_clear = (r_key == c_KEY_CLEAR);
    assign w_is_digit = (r_key <= 4'd9);

    // Clear always passes; a full accumulator blocks everything else, while a
    // full aux register only blocks further digit entry.
    assign w_accept = w_is_clear
                    | (w_is_digit & ~full_ACC & ~full_AUX)
                    | (w_is_op    & ~full_ACC);

    // ------------------------------------------------------------------
    // Optional busy_DISP timeout in WAIT_HI
    // ------------------------------------------------------------------
`ifdef CALC_FSM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] r_to_cnt;

    // Counts cycles spent in WAIT_HI; cleared everywhere else so each
    // handshake starts with a fresh budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT_HI) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // No counter in this build: WAIT_HI waits for busy_DISP forever.
    // TIMEOUT_CYCLES is meaningless here, the expression is constant false.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (key != KEY_NONE) w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = w_accept ? S_ACT : S_RELEASE;
            S_ACT:     w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (busy_DISP)      w_state_nxt = S_WAIT_LO;
                else if (w_timeout) w_state_nxt = S_RELEASE;
            end
            S_WAIT_LO: if (!busy_DISP)       w_state_nxt = S_RELEASE;
            S_RELEASE: if (key == KEY_NONE)  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, key latch and registered outputs
    // ------------------------------------------------------------------
    // Outputs are loaded on the DECODE->ACT edge so that digit/operation
    // change on the same edge that raises the strobes, and the strobes are
    // high for exactly the single ACT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key       <= KEY_NONE;
            r_digit     <= 4'd0;
            r_operation <= 2'b00;
            r_update    <= 1'b0;
            r_clear     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_update <= 1'b0;
            r_clear  <= 1'b0;

            if ((r_state == S_IDLE) && (key != KEY_NONE)) begin
                r_key <= key;
            end

            if ((r_state == S_DECODE) && w_accept) begin
                r_update <= 1'b1;
                if (w_is_clear) begin
                    r_clear     <= 1'b1;
                    r_digit     <= 4'd0;
                    r_operation <= 2'b00;
                end else if (w_is_digit) begin
                    r_digit     <= r_key;
                end else begin
                    r_operation <= w_op_code;
                end
            end
        end
    end

    assign digit       = r_digit;
    assign operation   = r_operation;
    assign update_DISP = r_update;
    assign clear_ALU   = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_calc_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_fsm
//  Description : Self-checking bench for calc_fsm. Directed key sequences
//                followed by random presses, compared against a behavioural
//                model of the calculator's key-acceptance rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_fsm;

    localparam logic [3:0] KEY_NONE = 4'd13;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic       full_ACC;
    logic       busy_DISP;
    logic       full_AUX;
    logic [3:0] digit;
    logic [1:0] operation;
    logic       update_DISP;
    logic       clear_ALU;

    int n_checks;
    int n_errors;

    // Model of the user-visible registers
    logic [3:0] m_digit;
    logic [1:0] m_op;

    calc_fsm #(
        .KEY_NONE       (KEY_NONE),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .full_ACC    (full_ACC),
        .busy_DISP   (busy_DISP),
        .full_AUX    (full_AUX),
        .digit       (digit),
        .operation   (operation),
        .update_DISP (update_DISP),
        .clear_ALU   (clear_ALU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acceptance rule: clear always; digits need neither register full;
    // operations only need room in the accumulator.
    function automatic bit model_accepts(input logic [3:0] k, input logic acc, input logic aux);
        if (k == 4'd15) return 1'b1;
        if (acc)        return 1'b0;
        if (k <= 4'd9)  return !aux;
        return 1'b1;
    endfunction

    function automatic logic [1:0] model_opcode(input logic [3:0] k);
        case (k)
            4'd10:   return 2'd0;
            4'd11:   return 2'd1;
            4'd12:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // One key press, starting on a falling edge with the FSM idle. The key is
    // held for 'hold' rising edges; the fake display raises busy 'bdel'
    // cycles after seeing update_DISP and keeps it up for 'blen' cycles.
    task automatic press(input logic [3:0] k, input int hold, input int bdel,
                         input int blen, input bit aux_at_upd, input string tag);
        bit         acc;
        logic [3:0] new_d;
        logic [1:0] new_o;
        int         n_upd, n_clr, upd_at, maxc;

        acc   = model_accepts(k, full_ACC, full_AUX);
        new_d = m_digit;
        new_o = m_op;
        if (acc) begin
            if (k == 4'd15) begin
                new_d = 4'd0;
                new_o = 2'd0;
            end else if (k <= 4'd9) begin
                new_d = k;
            end else begin
                new_o = model_opcode(k);
            end
        end

        n_upd  = 0;
        n_clr  = 0;
        upd_at = 0;
        maxc   = hold + bdel + blen + 6;
        key    = k;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (update_DISP === 1'b1) begin
                n_upd++;
                if (upd_at == 0) upd_at = c;
            end
            if (clear_ALU === 1'b1) n_clr++;
            if (c == 1) begin
                chk($sformatf("%s digit_before", tag), 32'(digit), 32'(m_digit));
                chk($sformatf("%s op_before", tag), 32'(operation), 32'(m_op));
            end
            if (c == 2) begin
                chk($sformatf("%s digit_at_strobe", tag), 32'(digit), 32'(new_d));
                chk($sformatf("%s op_at_strobe", tag), 32'(operation), 32'(new_o));
            end
            key = (c < hold) ? k : KEY_NONE;
            if (aux_at_upd && (upd_at == c) && (upd_at != 0)) full_AUX = 1'b1;
            busy_DISP = (upd_at > 0) && (c >= upd_at + bdel) && (c < upd_at + bdel + blen);
        end
        busy_DISP = 1'b0;
        key       = KEY_NONE;

        chk($sformatf("%s n_update", tag), 32'(n_upd), acc ? 32'd1 : 32'd0);
        chk($sformatf("%s n_clear", tag), 32'(n_clr), (acc && k == 4'd15) ? 32'd1 : 32'd0);
        chk($sformatf("%s update_cycle", tag), 32'(upd_at), acc ? 32'd2 : 32'd0);
        chk($sformatf("%s digit_after", tag), 32'(digit), 32'(new_d));
        chk($sformatf("%s op_after", tag), 32'(operation), 32'(new_o));

        m_digit = new_d;
        m_op    = new_o;
    endtask

    initial begin
        int         r;
        logic [3:0] k;

        n_checks  = 0;
        n_errors  = 0;
        m_digit   = 4'd0;
        m_op      = 2'd0;
        rst       = 1'b1;
        key       = KEY_NONE;
        full_ACC  = 1'b0;
        full_AUX  = 1'b0;
        busy_DISP = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset digit", 32'(digit), 32'd0);
        chk("reset operation", 32'(operation), 32'd0);
        chk("reset update", 32'(update_DISP), 32'd0);
        chk("reset clear", 32'(clear_ALU), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clear, digit, operation
        press(4'd15, 1, 1, 1, 1'b0, "clear");
        press(4'd7,  1, 1, 1, 1'b0, "digit7");
        press(4'd11, 1, 2, 3, 1'b0, "op_sub");

        // full_AUX rises mid-handshake, then blocks digits but not operations
        press(4'd8,  1, 2, 2, 1'b1, "digit8_aux");
        chk("aux set", 32'(full_AUX), 32'd1);
        press(4'd5,  1, 1, 1, 1'b0, "digit5_blocked");
        press(4'd10, 1, 1, 1, 1'b0, "op_add_aux");
        full_AUX = 1'b0;

        // full_ACC blocks digits and operations, never clear
        press(4'd3,  1, 1, 1, 1'b0, "digit3");
        full_ACC = 1'b1;
        press(4'd6,  1, 1, 1, 1'b0, "digit6_blocked");
        press(4'd10, 1, 1, 1, 1'b0, "op_add_blocked");
        press(4'd15, 1, 1, 1, 1'b0, "clear_acc");
        full_ACC = 1'b0;

        // Held key gives one event
        press(4'd4, 10, 1, 3, 1'b0, "held4");

        // Random presses
        for (int i = 0; i < 40; i++) begin
            full_ACC = ($urandom_range(0, 3) == 0);
            full_AUX = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 14));
            k = (r == 13) ? 4'd15 : 4'(r);
            press(k, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 4)), 1'b0, "rnd");
        end
        full_ACC = 1'b0;
        full_AUX = 1'b0;

        // Asynchronous reset while waiting for busy_DISP to fall
        press(4'd12, 1, 1, 1, 1'b0, "op_mul");
        key = 4'd4;
        @(negedge clk);
        key = KEY_NONE;
        @(negedge clk);
        chk("rst_seq update", 32'(update_DISP), 32'd1);
        busy_DISP = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_seq digit", 32'(digit), 32'd4);
        chk("rst_seq op", 32'(operation), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async rst digit", 32'(digit), 32'd0);
        chk("async rst operation", 32'(operation), 32'd0);
        chk("async rst update", 32'(update_DISP), 32'd0);
        chk("async rst clear", 32'(clear_ALU), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        busy_DISP = 1'b0;
        m_digit   = 4'd0;
        m_op      = 2'd0;
        @(negedge clk);
        // Idle again: a fresh press must respond with the normal latency
        press(4'd9, 1, 1, 1, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
